// File: rtl/alu_router_pkg.sv
// alu_router_pkg: shared constants, entry layout and destination decode for the ALU result router
package alu_router_pkg;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 2;
  localparam int NDEST_DEF = 4;
  localparam logic [1:0] DEST_RF   = 2'd0;
  localparam logic [1:0] DEST_MEM  = 2'd1;
  localparam logic [1:0] DEST_BR   = 2'd2;
  localparam logic [1:0] DEST_FLAG = 2'd3;
  typedef struct packed {
    logic [1:0]           sel;
    logic [DEF_WIDTH-1:0] data;
  } entry_t;
  function automatic logic [NDEST_DEF-1:0] dest_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction
endpackage

// File: rtl/alu_result_router_if.sv
// alu_result_router_if: ALU-side and consumer-side valid/ready bundle of the result router
interface alu_result_router_if
  import alu_router_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NDEST = NDEST_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [NDEST-1:0] out_valid;
  logic [NDEST-1:0] out_ready;
  logic [WIDTH-1:0] out_data;
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: generic power-of-two FIFO with async reset and synchronous flush
module alu_result_fifo #(
  parameter int DW    = 66,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;
  // next-state: flush wins over push/pop; pointers wrap naturally at DEPTH
  always_comb begin
    full          = cnt_q == CW'(DEPTH);
    empty         = cnt_q == '0;
    push_ok       = push && !full && !flush;
    pop_ok        = pop && !empty && !flush;
    mem_d         = mem_q;
    mem_d[wr_q]   = push_ok ? din : mem_q[wr_q];
    wr_d          = flush ? '0 : wr_q + AW'(push_ok);
    rd_d          = flush ? '0 : rd_q + AW'(pop_ok);
    cnt_d         = flush ? '0 : cnt_q + CW'(push_ok) - CW'(pop_ok);
    head          = mem_q[rd_q];
    count         = cnt_q;
  end
  // pointer and occupancy state, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: stale slots are never presented while count is zero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/alu_result_router.sv
// alu_result_router: buffers ALU results and routes the head to one of four consumers in program order
module alu_result_router
  import alu_router_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NDEST = NDEST_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  alu_result_router_if.slave     bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);
  logic                   rdy_q, rdy_d;
  logic                   full, empty, push, pop;
  logic [WIDTH+1:0]       head;
  logic [$clog2(DEPTH):0] fifo_count;
  alu_result_fifo #(.DW(WIDTH + 2), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({bus.in_sel, bus.in_data}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  // out-of-reset marker so in_ready rises only on the first edge after release
  always_comb rdy_d = 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= rdy_d;
  end
  // handshakes from registered state only; head decoded one-hot and zeroed when empty
  always_comb begin
    bus.in_ready  = rdy_q && !full && !flush;
    push          = bus.in_valid && bus.in_ready;
    bus.out_valid = empty ? '0 : NDEST'(dest_onehot(head[WIDTH+1:WIDTH]));
    bus.out_data  = empty ? '0 : head[WIDTH-1:0];
    pop           = |(bus.out_valid & bus.out_ready);
    count         = fifo_count;
    busy          = !empty;
  end
endmodule

// File: tb/tb_alu_result_router.sv
// tb_alu_result_router: scoreboard bench for the ALU result router
module tb_alu_result_router;
  import alu_router_pkg::*;
  localparam int DEPTH = 2;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] count;
  logic       busy;
  logic       mrdy;
  int         checks = 0;
  int         failures = 0;
  entry_t     q[$];
  alu_result_router_if #(.WIDTH(64), .NDEST(4)) bus ();
  alu_result_router #(.WIDTH(64), .DEPTH(DEPTH), .NDEST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .count (count),
    .busy  (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] s, input logic [63:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_sel   = s;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("send_timeout", 64'd1, 64'd0);
    step();
    bus.in_valid = 1'b0;
  endtask
  // model of "out of reset for at least one edge"
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mrdy <= 1'b0;
    else        mrdy <= 1'b1;
  end
  // mid-cycle monitor: compare outputs to scoreboard head, then apply this cycle's handshakes
  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = rst_n && mrdy && q.size() < DEPTH && !flush;
    chk("mon_in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
    chk("mon_count", {62'd0, count}, 64'(q.size()));
    chk("mon_busy", {63'd0, busy}, {63'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("mon_out_valid", {60'd0, bus.out_valid}, {60'd0, dest_onehot(q[0].sel)});
      chk("mon_out_data", bus.out_data, q[0].data);
    end else begin
      chk("mon_idle_valid", {60'd0, bus.out_valid}, 64'd0);
      chk("mon_idle_data", bus.out_data, 64'd0);
    end
    if (!rst_n) q.delete();
    else begin
      if (q.size() != 0 && bus.out_ready[q[0].sel]) void'(q.pop_front());
      if (bus.in_valid && exp_rdy) q.push_back('{sel: bus.in_sel, data: bus.in_data});
      if (flush) q.delete();
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = DEST_RF;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;
    repeat (2) step();
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst_n = 1'b1;
    chk("rel_in_ready_pre", {63'd0, bus.in_ready}, 64'd0);
    step();
    chk("rel_in_ready_post", {63'd0, bus.in_ready}, 64'd1);
    // single pass
    bus.out_ready = 4'b1111;
    send(DEST_BR, 64'h0000_0000_DEAD_BEEF);
    chk("single_valid", {60'd0, bus.out_valid}, 64'b0100);
    chk("single_data", bus.out_data, 64'h0000_0000_DEAD_BEEF);
    step();
    chk("single_count", {62'd0, count}, 64'd0);
    // back-pressure and head-of-line blocking
    bus.out_ready = 4'b0000;
    send(DEST_RF, 64'hAAAA_0000_0000_000A);
    send(DEST_FLAG, 64'hBBBB_0000_0000_000B);
    chk("bp_count", {62'd0, count}, 64'd2);
    chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    bus.in_valid = 1'b1;
    bus.in_sel   = DEST_MEM;
    bus.in_data  = 64'hCCCC_0000_0000_000C;
    repeat (2) step();
    bus.in_valid = 1'b0;
    chk("bp_third_rejected", {62'd0, count}, 64'd2);
    bus.out_ready = 4'b1000;
    step();
    chk("bp_hold_valid", {60'd0, bus.out_valid}, 64'b0001);
    chk("bp_hold_data", bus.out_data, 64'hAAAA_0000_0000_000A);
    chk("bp_hold_count", {62'd0, count}, 64'd2);
    bus.out_ready = 4'b1001;
    step();
    chk("bp_b_valid", {60'd0, bus.out_valid}, 64'b1000);
    chk("bp_b_data", bus.out_data, 64'hBBBB_0000_0000_000B);
    step();
    chk("bp_drained", {62'd0, count}, 64'd0);
    // sustained push/pop throughput
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_sel  = 2'(i % 4);
      bus.in_data = 64'(100 + i);
      chk("tput_in_ready", {63'd0, bus.in_ready}, 64'd1);
      if (i > 0) begin
        chk("tput_count", {62'd0, count}, 64'd1);
        chk("tput_head", bus.out_data, 64'(100 + i - 1));
      end
      step();
    end
    bus.in_valid = 1'b0;
    chk("tput_last", bus.out_data, 64'd107);
    step();
    chk("tput_drained", {62'd0, count}, 64'd0);
    // pointer wrap
    for (int i = 1; i <= 5; i++) begin
      send(2'(i % 4), 64'(i));
      chk("wrap_data", bus.out_data, 64'(i));
    end
    step();
    chk("wrap_drained", {62'd0, count}, 64'd0);
    // flush with a concurrent push attempt
    bus.out_ready = 4'b0000;
    send(DEST_MEM, 64'h1111);
    send(DEST_BR, 64'h2222);
    chk("flush_pre_count", {62'd0, count}, 64'd2);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = DEST_RF;
    bus.in_data  = 64'h3333;
    #1;
    chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_count", {62'd0, count}, 64'd0);
    chk("flush_valid", {60'd0, bus.out_valid}, 64'd0);
    step();
    chk("flush_not_stored", {62'd0, count}, 64'd0);
    // asynchronous reset mid-stream
    send(DEST_RF, 64'h4444);
    send(DEST_FLAG, 64'h5555);
    chk("rst_pre_count", {62'd0, count}, 64'd2);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_valid", {60'd0, bus.out_valid}, 64'd0);
    chk("rst_count", {62'd0, count}, 64'd0);
    chk("rst_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    chk("rst_rel_pre", {63'd0, bus.in_ready}, 64'd0);
    step();
    chk("rst_rel_post", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 4'b1111;
    send(DEST_MEM, 64'h6666);
    chk("post_rst_valid", {60'd0, bus.out_valid}, 64'b0010);
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
